lfsr_seq_ctrl: RTL and testbench

Sequencer for a scan-style LFSR register chain, i.e. WIDTH cascaded cells, each with a `sel1` input mux (scan-in or ground) feeding a `sel` mux (functional D or shift path). The block serially loads a seed, runs the LFSR functionally for a programmed number of cycles, then shifts the chain out while flushing zeros in, and captures the signature. It sits between the test/config host (start/abort handshake) and the shared `sel`/`sel1`/scan-in control lines of the chain.

---
 rtl/lfsr_seq_pkg.sv | 18 +
 rtl/lfsr_seq_ctrl_if.sv | 28 ++
 rtl/lfsr_seq_cnt.sv | 38 +++
 rtl/lfsr_seq_ctrl.sv | 174 +++++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_seq_pkg.sv
// Shared types and mux encodings for the scan-LFSR sequencer.
// Pure definitions: no latency, no flow control.
package lfsr_seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        UNLOAD = 3'd3,
        DONE   = 3'd4
    } state_e;

    localparam logic SEL_FUNC  = 1'b1;
    localparam logic SEL_SHIFT = 1'b0;
    localparam logic SEL1_SCAN = 1'b1;
    localparam logic SEL1_GND  = 1'b0;

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Host handshake plus chain control lines of the LFSR sequencer.
// Master = host/chain side, slave = sequencer; no flow control beyond start/abort.
interface lfsr_seq_ctrl_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] seed;
    logic [CNT_W-1:0] run_len;
    logic             scan_out;
    logic             sel;
    logic             sel1;
    logic             scan_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] signature;

    modport master (
        output start, abort, seed, run_len, scan_out,
        input  sel, sel1, scan_in, busy, done, signature
    );

    modport slave (
        input  start, abort, seed, run_len, scan_out,
        output sel, sel1, scan_in, busy, done, signature
    );
endinterface

// File: rtl/lfsr_seq_cnt.sv
// Loadable down counter shared by all sequencer phases; saturates at zero.
// Next value visible combinationally on cnt_nxt; zero reflects the registered count.
module lfsr_seq_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] cnt_nxt,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_nxt = cnt_d;
    assign zero    = (cnt_q == '0);

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Seed-load / run / unload sequencer for a scan LFSR chain; DONE lands 1+2*WIDTH+run_len cycles after accept.
// Start accepted only in IDLE (no queueing); abort returns to IDLE next edge except in DONE.
module lfsr_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    lfsr_seq_ctrl_if.slave bus
);
    import lfsr_seq_pkg::*;

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [CNT_W-1:0] run_q, run_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] signature_q, signature_d;
    logic             sel_q, sel_d;
    logic             sel1_q, sel1_d;
    logic             scan_in_q, scan_in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_zero;

    lfsr_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .cnt_nxt  (cnt_nxt),
        .zero     (cnt_zero)
    );

    // Next-state: the counter is reloaded on every phase entry and runs down to zero.
    always_comb begin
        state_d  = state_q;
        seed_d   = seed_q;
        run_d    = run_q;
        sh_d     = sh_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d  = LOAD;
                    seed_d   = bus.seed;
                    run_d    = bus.run_len;
                    cnt_load = 1'b1;
                    cnt_val  = LAST_BIT;
                end
            end
            LOAD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    cnt_load = 1'b1;
                    if (run_q != '0) begin
                        state_d = RUN;
                        cnt_val = run_q - CNT_W'(1);
                    end else begin
                        state_d = UNLOAD;
                        cnt_val = LAST_BIT;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (cnt_zero) begin
                    state_d  = UNLOAD;
                    cnt_load = 1'b1;
                    cnt_val  = LAST_BIT;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            UNLOAD: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    sh_d = {sh_q[WIDTH-2:0], bus.scan_out};
                    if (cnt_zero) begin
                        state_d = DONE;
                    end else begin
                        cnt_dec = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the next state/count so the registered values line up with the state.
    always_comb begin
        sel_d       = SEL_SHIFT;
        sel1_d      = SEL1_GND;
        scan_in_d   = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        signature_d = signature_q;
        case (state_d)
            LOAD: begin
                sel1_d    = SEL1_SCAN;
                scan_in_d = seed_d[cnt_nxt[IDX_W-1:0]];
                busy_d    = 1'b1;
            end
            RUN: begin
                sel_d  = SEL_FUNC;
                busy_d = 1'b1;
            end
            UNLOAD: begin
                busy_d = 1'b1;
            end
            DONE: begin
                done_d      = 1'b1;
                signature_d = sh_d;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            seed_q      <= '0;
            run_q       <= '0;
            sh_q        <= '0;
            signature_q <= '0;
            sel_q       <= 1'b0;
            sel1_q      <= 1'b0;
            scan_in_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            seed_q      <= seed_d;
            run_q       <= run_d;
            sh_q        <= sh_d;
            signature_q <= signature_d;
            sel_q       <= sel_d;
            sel1_q      <= sel1_d;
            scan_in_q   <= scan_in_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel1      = sel1_q;
    assign bus.scan_in   = scan_in_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = signature_q;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench: 8-stage scan chain with Fibonacci feedback (taps 8,6,5,4) driven by the sequencer.
module tb_lfsr_seq_ctrl;
    localparam int W = 8;
    localparam int C = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    lfsr_seq_ctrl_if #(.WIDTH(W), .CNT_W(C)) bus ();

    lfsr_seq_ctrl #(.WIDTH(W), .CNT_W(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Chain stage 0 takes scan_in, stage 7 drives scan_out; not reset, like the real chain.
    logic [7:0] chain_q = 8'hFF;

    function automatic logic [7:0] lfsr_step(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    always @(posedge clk) begin
        if (bus.sel) chain_q <= lfsr_step(chain_q);
        else         chain_q <= {chain_q[6:0], bus.sel1 & bus.scan_in};
    end

    assign bus.scan_out = chain_q[7];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic start_seq(input logic [7:0] s, input logic [15:0] len);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.seed    = s;
        bus.run_len = len;
        @(negedge clk);
        bus.start   = 1'b0;
    endtask

    // Counts cycles since accept until done is seen, bounded.
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 1000) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.seed    = '0;
        bus.run_len = '0;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.sel !== 1'b0) begin n_bad++; $display("FAIL rst_sel got %b want 0", bus.sel); end
        n_cmp++; if (bus.sel1 !== 1'b0) begin n_bad++; $display("FAIL rst_sel1 got %b want 0", bus.sel1); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", bus.done); end
        n_cmp++; if (bus.signature !== 8'h00) begin n_bad++; $display("FAIL rst_sig got %h want 00", bus.signature); end
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        n_cmp++; if (chain_q !== 8'h00) begin n_bad++; $display("FAIL rst_flush got %h want 00", chain_q); end
    endtask

    task automatic test_loopback();
        int lat;
        start_seq(8'hA5, 16'd0);
        n_cmp++; if (bus.sel1 !== 1'b1) begin n_bad++; $display("FAIL load_sel1 got %b want 1", bus.sel1); end
        n_cmp++; if (bus.sel !== 1'b0) begin n_bad++; $display("FAIL load_sel got %b want 0", bus.sel); end
        n_cmp++; if (bus.scan_in !== 1'b1) begin n_bad++; $display("FAIL load_bit7 got %b want 1", bus.scan_in); end
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL load_busy got %b want 1", bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.scan_in !== 1'b0) begin n_bad++; $display("FAIL load_bit6 got %b want 0", bus.scan_in); end
        wait_done(2, lat);
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL loop_latency got %0d want 17", lat); end
        n_cmp++; if (bus.signature !== 8'hA5) begin n_bad++; $display("FAIL loop_sig got %h want a5", bus.signature); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL done_busy got %b want 0", bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse got %b want 0", bus.done); end
        n_cmp++; if (bus.signature !== 8'hA5) begin n_bad++; $display("FAIL sig_hold got %h want a5", bus.signature); end
    endtask

    task automatic test_lfsr_run();
        int lat;
        start_seq(8'h01, 16'd1);
        wait_done(1, lat);
        n_cmp++; if (lat !== 18) begin n_bad++; $display("FAIL run1_latency got %0d want 18", lat); end
        n_cmp++; if (bus.signature !== 8'h02) begin n_bad++; $display("FAIL run1_sig got %h want 02", bus.signature); end
        start_seq(8'h01, 16'd255);
        wait_done(1, lat);
        n_cmp++; if (lat !== 272) begin n_bad++; $display("FAIL run255_latency got %0d want 272", lat); end
        n_cmp++; if (bus.signature !== 8'h01) begin n_bad++; $display("FAIL run255_sig got %h want 01", bus.signature); end
    endtask

    task automatic test_abort();
        int lat;
        int seen;
        start_seq(8'h5A, 16'd0);
        wait_done(1, lat);
        n_cmp++; if (bus.signature !== 8'h5A) begin n_bad++; $display("FAIL pre_abort_sig got %h want 5a", bus.signature); end
        start_seq(8'hC3, 16'd10);
        repeat (10) @(negedge clk);
        n_cmp++; if (bus.sel !== 1'b1) begin n_bad++; $display("FAIL run_sel got %b want 1", bus.sel); end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.sel !== 1'b0) begin n_bad++; $display("FAIL abort_sel got %b want 0", bus.sel); end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_done got %0d pulses want 0", seen); end
        n_cmp++; if (bus.signature !== 8'h5A) begin n_bad++; $display("FAIL abort_sig got %h want 5a", bus.signature); end
    endtask

    task automatic test_ignore();
        int lat;
        start_seq(8'h3C, 16'd0);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.seed    = 8'hFF;
        bus.run_len = 16'd5;
        @(negedge clk);
        bus.start   = 1'b0;
        wait_done(3, lat);
        n_cmp++; if (lat !== 17) begin n_bad++; $display("FAIL ign_load_latency got %0d want 17", lat); end
        n_cmp++; if (bus.signature !== 8'h3C) begin n_bad++; $display("FAIL ign_load_sig got %h want 3c", bus.signature); end
        bus.start   = 1'b1;
        bus.seed    = 8'h11;
        bus.run_len = 16'd0;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_done_busy got %b want 0", bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ign_done_busy2 got %b want 0", bus.busy); end
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL start_abort_busy got %b want 0", bus.busy); end
        @(negedge clk);
        n_cmp++; if (bus.sel1 !== 1'b0) begin n_bad++; $display("FAIL start_abort_sel1 got %b want 0", bus.sel1); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_seq(8'hA5, 16'd0);
        wait_done(1, lat);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.seed    = 8'h01;
        bus.run_len = 16'd3;
        @(negedge clk);
        bus.start = 1'b0;
        n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got %b want 1", bus.busy); end
        repeat (8) @(negedge clk);
        n_cmp++; if (bus.sel !== 1'b1) begin n_bad++; $display("FAIL b2b_run_sel got %b want 1", bus.sel); end
        wait_done(9, lat);
        n_cmp++; if (lat !== 20) begin n_bad++; $display("FAIL b2b_latency got %0d want 20", lat); end
        n_cmp++; if (bus.signature !== 8'h08) begin n_bad++; $display("FAIL b2b_sig got %h want 08", bus.signature); end
    endtask

    task automatic test_reset_mid_run();
        start_seq(8'hFF, 16'd20);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.sel !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sel got %b want 0", bus.sel); end
        n_cmp++; if (bus.sel1 !== 1'b0) begin n_bad++; $display("FAIL mid_rst_sel1 got %b want 0", bus.sel1); end
        n_cmp++; if (bus.scan_in !== 1'b0) begin n_bad++; $display("FAIL mid_rst_scan_in got %b want 0", bus.scan_in); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_busy got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL mid_rst_done got %b want 0", bus.done); end
        n_cmp++; if (bus.signature !== 8'h00) begin n_bad++; $display("FAIL mid_rst_sig got %h want 00", bus.signature); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_cmp++; if (chain_q !== 8'h00) begin n_bad++; $display("FAIL mid_rst_flush got %h want 00", chain_q); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_rst_idle got %b want 0", bus.busy); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_lfsr_run();
        test_abort();
        test_ignore();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
